// File: rtl/image_storage_pkg.sv
// Shared SRAM-interface constants and write-side FSM states for the image buffers.
package image_storage_pkg;

  localparam logic [1:0] SI_MODE_IDLE  = 2'b00;
  localparam logic [1:0] SI_MODE_READ  = 2'b01;
  localparam logic [1:0] SI_MODE_WRITE = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} wr_state_t;

endpackage

// File: rtl/pixel_word_packer.sv
// Packs result pixels into SRAM words, tracks the running pixel index and the
// lane-0 index of the word being built; a completed word that cannot leave waits here.
module pixel_word_packer #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [PIX_W-1:0]  pix,
  input  logic              last,
  input  logic              take,
  output logic              word_valid,
  output logic [DATA_W-1:0] word_data,
  output logic [ADDR_W-1:0] word_idx,
  output logic              pack_full
);

  localparam int unsigned PPW    = DATA_W / PIX_W;
  localparam int unsigned LANE_W = $clog2(PPW);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [DATA_W-1:0] data_q, data_d, merged;
  logic [ADDR_W-1:0] idx_q, idx_d, base_q, base_d;
  logic              full_q, full_d;
  logic              complete;

  always_comb begin
    merged = data_q;
    merged[lane_q*PIX_W +: PIX_W] = pix;
    complete   = accept && ((lane_q == LANE_W'(PPW - 1)) || last);
    word_valid = complete || full_q;
    word_data  = full_q ? data_q : merged;
    // A word still in lane 0 has not captured its base yet; use the live index.
    word_idx   = (full_q || (lane_q != '0)) ? base_q : idx_q;
    pack_full  = full_q;
  end

  always_comb begin
    lane_d = lane_q;
    data_d = data_q;
    idx_d  = idx_q;
    base_d = base_q;
    full_d = full_q;
    if (clear) begin
      lane_d = '0;
      data_d = '0;
      idx_d  = '0;
      base_d = '0;
      full_d = 1'b0;
    end else begin
      if (full_q && take) begin
        full_d = 1'b0;
        lane_d = '0;
        data_d = '0;
      end
      if (accept) begin
        idx_d = idx_q + 1'b1;
        if (lane_q == '0) base_d = idx_q;
        if (complete && take) begin
          lane_d = '0;
          data_d = '0;
        end else if (complete) begin
          data_d = merged;
          full_d = 1'b1;
        end else begin
          data_d = merged;
          lane_d = lane_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
      data_q <= '0;
      idx_q  <= '0;
      base_q <= '0;
      full_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      data_q <= data_d;
      idx_q  <= idx_d;
      base_q <= base_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/result_image_data_storage.sv
// Writes packed edge-detector result pixels to SRAM through the SI port, with a
// one-word holding register so the pixel stream keeps flowing during a write.
module result_image_data_storage
  import image_storage_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 20,
  parameter int unsigned       PIX_W    = 8,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] OUT_BASE = 'h4B000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PIX_W-1:0]  ED_wdata,
  input  logic              ED_wvalid,
  input  logic              ED_wlast,
  output logic              ED_wready,
  input  logic              SI_dfb,
  output logic [1:0]        SI_mode,
  output logic [ADDR_W-1:0] SI_wpixNum,
  output logic [DATA_W-1:0] SI_wdata,
  output logic              frame_done
);

  wr_state_t         state_q, state_d;
  logic              hold_valid_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [DATA_W-1:0] hold_data_q;

  logic              accept, hold_ready, clear, transfer;
  logic              word_valid, pack_full;
  logic [DATA_W-1:0] word_data;
  logic [ADDR_W-1:0] word_idx;

  assign ED_wready  = (state_q == RUN) && !pack_full;
  assign accept     = ED_wvalid && ED_wready;
  // Hold can take a new word when empty or when it drains on this same edge.
  assign hold_ready = !hold_valid_q || SI_dfb;
  assign clear      = (state_q == IDLE) && start;
  assign transfer   = word_valid && hold_ready;

  pixel_word_packer #(
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W),
    .DATA_W (DATA_W)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .accept     (accept),
    .pix        (ED_wdata),
    .last       (ED_wlast),
    .take       (hold_ready),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_idx   (word_idx),
    .pack_full  (pack_full)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && ED_wlast) state_d = DRAIN;
      DRAIN:   if (hold_valid_q && SI_dfb && !pack_full) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
    end else if (transfer) begin
      hold_valid_q <= 1'b1;
      hold_addr_q  <= OUT_BASE + word_idx;
      hold_data_q  <= word_data;
    end else if (SI_dfb) begin
      hold_valid_q <= 1'b0;
    end
  end

  assign SI_mode    = hold_valid_q ? SI_MODE_WRITE : SI_MODE_IDLE;
  assign SI_wpixNum = hold_valid_q ? hold_addr_q : '0;
  assign SI_wdata   = hold_valid_q ? hold_data_q : '0;
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_result_image_data_storage.sv
// Scoreboard bench: two instances (default base and a base that wraps) share stimulus.
module tb_result_image_data_storage;

  logic        clk = 1'b0;
  logic        rst, start, ED_wvalid, ED_wlast, SI_dfb;
  logic [7:0]  ED_wdata;
  logic        m_ready, m_done, w_ready, w_done;
  logic [1:0]  m_mode, w_mode;
  logic [19:0] m_addr, w_addr;
  logic [31:0] m_data, w_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [19:0] off;
    logic [31:0] data;
  } exp_t;
  exp_t q_m[$];
  exp_t q_w[$];

  always #5 clk = ~clk;

  result_image_data_storage u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ED_wdata   (ED_wdata),
    .ED_wvalid  (ED_wvalid),
    .ED_wlast   (ED_wlast),
    .ED_wready  (m_ready),
    .SI_dfb     (SI_dfb),
    .SI_mode    (m_mode),
    .SI_wpixNum (m_addr),
    .SI_wdata   (m_data),
    .frame_done (m_done)
  );

  result_image_data_storage #(
    .OUT_BASE (20'hFFFFE)
  ) u_dut_wrap (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ED_wdata   (ED_wdata),
    .ED_wvalid  (ED_wvalid),
    .ED_wlast   (ED_wlast),
    .ED_wready  (w_ready),
    .SI_dfb     (SI_dfb),
    .SI_mode    (w_mode),
    .SI_wpixNum (w_addr),
    .SI_wdata   (w_data),
    .frame_done (w_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [19:0] off, input logic [31:0] data);
    exp_t e;
    e.off  = off;
    e.data = data;
    q_m.push_back(e);
    q_w.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    sync();
    start = 1'b0;
  endtask

  task automatic dfb_pulse();
    SI_dfb = 1'b1;
    sync();
    SI_dfb = 1'b0;
  endtask

  task automatic push(input logic [7:0] p, input logic l);
    int n = 0;
    ED_wdata  = p;
    ED_wvalid = 1'b1;
    ED_wlast  = l;
    @(negedge clk);
    while (!m_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!m_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got ready=0 expected ready=1 for pixel %h", p);
    end
    sync();
    ED_wvalid = 1'b0;
    ED_wlast  = 1'b0;
  endtask

  // Monitor: every completed write (mode=10 with SI_dfb) is checked against the queue.
  always @(negedge clk) begin
    exp_t        e;
    logic [19:0] ea;
    if (!rst && SI_dfb) begin
      if (m_mode == 2'b10) begin
        if (q_m.size() == 0) begin
          check("m_unexpected_write", 32'(m_addr), 32'hFFFFFFFF);
        end else begin
          e  = q_m.pop_front();
          ea = 20'h4B000 + e.off;
          check("m_wr_addr", 32'(m_addr), 32'(ea));
          check("m_wr_data", m_data, e.data);
        end
      end
      if (w_mode == 2'b10) begin
        if (q_w.size() == 0) begin
          check("w_unexpected_write", 32'(w_addr), 32'hFFFFFFFF);
        end else begin
          e  = q_w.pop_front();
          ea = 20'hFFFFE + e.off;
          check("w_wr_addr", 32'(w_addr), 32'(ea));
          check("w_wr_data", w_data, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; ED_wvalid = 1'b0; ED_wlast = 1'b0; ED_wdata = '0; SI_dfb = 1'b0;
    #2;
    check("rst_mode", 32'(m_mode), 32'h0);
    check("rst_addr", 32'(m_addr), 32'h0);
    check("rst_data", m_data, 32'h0);
    check("rst_ready", 32'(m_ready), 32'h0);
    check("rst_done", 32'(m_done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sync();
    check("idle_ready", 32'(m_ready), 32'h0);
    check("idle_mode", 32'(m_mode), 32'h0);

    // Frame A: one full word, last on lane 3
    pulse_start();
    sb_push(20'h0, 32'h44332211);
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b1);
    @(negedge clk);
    check("a_mode", 32'(m_mode), 32'h2);
    check("a_addr", 32'(m_addr), 32'h4B000);
    check("a_data", m_data, 32'h44332211);
    check("a_ready_drain", 32'(m_ready), 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("a_stable_mode", 32'(m_mode), 32'h2);
      check("a_stable_data", m_data, 32'h44332211);
    end
    sync();
    dfb_pulse();
    @(negedge clk);
    check("a_post_mode", 32'(m_mode), 32'h0);
    check("a_post_addr", 32'(m_addr), 32'h0);
    check("a_post_data", m_data, 32'h0);
    check("a_done", 32'(m_done), 32'h1);
    @(negedge clk);
    check("a_done_pulse", 32'(m_done), 32'h0);

    // Frame B: back-pressure when hold and pack are both full
    sync();
    pulse_start();
    sb_push(20'h0, 32'h04030201);
    sb_push(20'h4, 32'h08070605);
    sb_push(20'h8, 32'h0C0B0A09);
    for (int i = 1; i <= 8; i++) push(8'(i), 1'b0);
    @(negedge clk);
    check("b_full_ready", 32'(m_ready), 32'h0);
    check("b_hold_addr", 32'(m_addr), 32'h4B000);
    sync();
    @(negedge clk);
    check("b_full_ready2", 32'(m_ready), 32'h0);
    sync();
    dfb_pulse();
    @(negedge clk);
    check("b_addr_w1", 32'(m_addr), 32'h4B004);
    check("b_wrap_addr_w1", 32'(w_addr), 32'h00002);
    check("b_ready_again", 32'(m_ready), 32'h1);
    check("b_mode_w1", 32'(m_mode), 32'h2);
    sync();
    dfb_pulse();
    for (int i = 9; i <= 12; i++) push(8'(i), i == 12);
    @(negedge clk);
    check("b_addr_w2", 32'(m_addr), 32'h4B008);
    check("b_wrap_addr_w2", 32'(w_addr), 32'h00006);
    sync();
    dfb_pulse();
    @(negedge clk);
    check("b_done", 32'(m_done), 32'h1);

    // Frame C: partial final word, zero padded
    sync();
    pulse_start();
    sb_push(20'h0, 32'h04030201);
    sb_push(20'h4, 32'h0000B6A5);
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h04, 1'b0);
    push(8'hA5, 1'b0); push(8'hB6, 1'b1);
    @(negedge clk);
    check("c_hold_addr", 32'(m_addr), 32'h4B000);
    sync();
    dfb_pulse();
    @(negedge clk);
    check("c_addr_w1", 32'(m_addr), 32'h4B004);
    check("c_data_w1", m_data, 32'h0000B6A5);
    check("c_not_done", 32'(m_done), 32'h0);
    sync();
    dfb_pulse();
    @(negedge clk);
    check("c_done", 32'(m_done), 32'h1);
    check("c_mode_idle", 32'(m_mode), 32'h0);
    @(negedge clk);
    check("c_done_pulse", 32'(m_done), 32'h0);

    // Frame D: SI_dfb coincides with the accept that completes word 1
    sync();
    pulse_start();
    sb_push(20'h0, 32'h34333231);
    sb_push(20'h4, 32'h38373635);
    for (int i = 0; i < 7; i++) push(8'(8'h31 + i), 1'b0);
    @(negedge clk);
    check("d_pre_mode", 32'(m_mode), 32'h2);
    sync();
    SI_dfb = 1'b1;
    push(8'h38, 1'b1);
    SI_dfb = 1'b0;
    @(negedge clk);
    check("d_no_gap_mode", 32'(m_mode), 32'h2);
    check("d_addr_w1", 32'(m_addr), 32'h4B004);
    check("d_data_w1", m_data, 32'h38373635);
    sync();
    dfb_pulse();
    @(negedge clk);
    check("d_done", 32'(m_done), 32'h1);

    // Frame E: address wrap on the second instance; start during RUN ignored
    sync();
    pulse_start();
    sb_push(20'h0, 32'h54535251);
    sb_push(20'h4, 32'h58575655);
    push(8'h51, 1'b0); push(8'h52, 1'b0); push(8'h53, 1'b0);
    start = 1'b1;
    push(8'h54, 1'b0);
    start = 1'b0;
    push(8'h55, 1'b0); push(8'h56, 1'b0); push(8'h57, 1'b0); push(8'h58, 1'b1);
    @(negedge clk);
    check("e_wrap_addr_w0", 32'(w_addr), 32'hFFFFE);
    check("e_addr_w0", 32'(m_addr), 32'h4B000);
    sync();
    dfb_pulse();
    @(negedge clk);
    check("e_wrap_addr_w1", 32'(w_addr), 32'h00002);
    check("e_wrap_data_w1", w_data, 32'h58575655);
    sync();
    dfb_pulse();
    @(negedge clk);
    check("e_done", 32'(m_done), 32'h1);
    check("e_wrap_done", 32'(w_done), 32'h1);

    // Mid-frame asynchronous reset drops the pending write
    sync();
    pulse_start();
    for (int i = 0; i < 4; i++) push(8'(8'h61 + i), 1'b0);
    @(negedge clk);
    check("r_pre_mode", 32'(m_mode), 32'h2);
    sync();
    #2;
    rst = 1'b1;
    #1;
    check("r_async_mode", 32'(m_mode), 32'h0);
    check("r_async_wrap_mode", 32'(w_mode), 32'h0);
    check("r_async_ready", 32'(m_ready), 32'h0);
    check("r_async_wrap_ready", 32'(w_ready), 32'h0);
    check("r_async_done", 32'(m_done), 32'h0);
    check("r_async_addr", 32'(m_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sync();
    check("r_idle_ready", 32'(m_ready), 32'h0);
    check("r_idle_mode", 32'(m_mode), 32'h0);

    check("sb_empty_m", 32'(q_m.size()), 32'h0);
    check("sb_empty_w", 32'(q_w.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
